// File: rtl/mp_alu_seq_if.sv
// Request/response and byte-ALU signals of mp_alu_seq. The slave side is the sequencer.
// The master side is the requester together with the external combinational ALU.
interface mp_alu_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  len;
    logic        cin;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        zero_flag;
    logic [2:0]  alu_cmd;
    logic [7:0]  alu_inA;
    logic [7:0]  alu_inB;
    logic        alu_sc_i;
    logic [7:0]  alu_rslt;
    logic        alu_sc_o;

    modport master (
        output start, op, len, cin, a_in, b_in, alu_rslt, alu_sc_o,
        input  ready, done, result, carry_out, zero_flag,
        input  alu_cmd, alu_inA, alu_inB, alu_sc_i
    );

    modport slave (
        input  start, op, len, cin, a_in, b_in, alu_rslt, alu_sc_o,
        output ready, done, result, carry_out, zero_flag,
        output alu_cmd, alu_inA, alu_inB, alu_sc_i
    );
endinterface

// File: rtl/mp_alu_seq.sv
// Multi-precision ALU sequencer: drives an external byte ALU over 1..4 bytes, one byte per cycle.
// done pulses n+1 cycles after an n-byte request is accepted; start is ignored unless ready.
module mp_alu_seq (
    input  logic          clk,
    input  logic          reset,
    mp_alu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    state_t      state, state_nxt;
    logic [1:0]  op_q, len_q, idx;
    logic [31:0] a_q, b_q, result_q, result_nxt;
    logic        carry_q, zero_q;
    logic        last_byte;
    logic [4:0]  bit_ofs;

    assign bit_ofs   = {idx, 3'b000};
    // SHR walks from the top byte down so the shift-out bit ripples toward byte 0.
    assign last_byte = (op_q == OP_SHR) ? (idx == 2'd0) : (idx == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.alu_cmd  = 3'b000;
        bus.alu_inA  = 8'h00;
        bus.alu_inB  = 8'h00;
        bus.alu_sc_i = 1'b0;
        result_nxt   = result_q;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                bus.alu_cmd  = {1'b0, op_q};
                bus.alu_inA  = a_q[bit_ofs +: 8];
                bus.alu_inB  = (op_q == OP_ADD || op_q == OP_NAND) ? b_q[bit_ofs +: 8] : 8'h00;
                bus.alu_sc_i = carry_q;
                result_nxt[bit_ofs +: 8] = bus.alu_rslt;
                if (last_byte) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= 2'b00;
            len_q    <= 2'b00;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            idx      <= 2'd0;
            result_q <= 32'h0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        len_q    <= bus.len;
                        a_q      <= bus.a_in;
                        b_q      <= bus.b_in;
                        idx      <= (bus.op == OP_SHR) ? bus.len : 2'd0;
                        result_q <= 32'h0;
                        zero_q   <= 1'b1;
                        carry_q  <= (bus.op == OP_NAND) ? 1'b0 : bus.cin;
                    end
                end
                RUN: begin
                    result_q <= result_nxt;
                    zero_q   <= (result_nxt == 32'h0);
                    carry_q  <= (op_q == OP_NAND) ? 1'b0 : bus.alu_sc_o;
                    if (last_byte) begin
                        idx <= 2'd0;
                    end else if (op_q == OP_SHR) begin
                        idx <= idx - 2'd1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_flag = zero_q;
endmodule

// File: tb/tb_mp_alu_seq.sv
// Directed bench for mp_alu_seq with a behavioural byte ALU on the datapath side.
module tb_mp_alu_seq;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   done_seen;

    mp_alu_seq_if bus ();

    mp_alu_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte ALU: ADD with carry, SHL/SHR through the carry bit, NAND.
    always_comb begin
        logic [8:0] sum;
        sum = {1'b0, bus.alu_inA} + {1'b0, bus.alu_inB} + {8'h00, bus.alu_sc_i};
        bus.alu_rslt = 8'h00;
        bus.alu_sc_o = 1'b0;
        case (bus.alu_cmd)
            3'b000: begin bus.alu_rslt = sum[7:0]; bus.alu_sc_o = sum[8]; end
            3'b001: begin bus.alu_rslt = {bus.alu_inA[6:0], bus.alu_sc_i}; bus.alu_sc_o = bus.alu_inA[7]; end
            3'b010: begin bus.alu_rslt = {bus.alu_sc_i, bus.alu_inA[7:1]}; bus.alu_sc_o = bus.alu_inA[0]; end
            3'b011: begin bus.alu_rslt = ~(bus.alu_inA & bus.alu_inB); end
            default: begin end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat counts cycles after the accepting edge; the cycle right after that edge is 1.
    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
        if (bus.done) done_seen++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] len, input logic cin,
                         input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.len   = len;
        bus.cin   = cin;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
    endtask

    task automatic wait_done(input string tag, input int nbytes, input logic [31:0] er,
                             input logic ec, input logic ez);
        while (!bus.done && lat < 20) tick();
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(nbytes + 1));
        check({tag, "_res"}, bus.result, er);
        check({tag, "_cout"}, 32'(bus.carry_out), 32'(ec));
        check({tag, "_zf"}, 32'(bus.zero_flag), 32'(ez));
        tick();
        check({tag, "_rdy"}, 32'(bus.ready), 32'd1);
        check({tag, "_hold"}, bus.result, er);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        lat = 0;
        done_seen = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.len = 2'b00;
        bus.cin = 1'b0;
        bus.a_in = 32'h0;
        bus.b_in = 32'h0;
        #12;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_cout", 32'(bus.carry_out), 32'd0);
        check("rst_zf", 32'(bus.zero_flag), 32'd1);
        check("rst_cmd", 32'(bus.alu_cmd), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        issue(2'b00, 2'd1, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        wait_done("add2", 2, 32'h0000_0100, 1'b0, 1'b0);
        issue(2'b00, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done("add4", 4, 32'h0000_0000, 1'b1, 1'b1);
        issue(2'b01, 2'd1, 1'b1, 32'h0000_8001, 32'hDEAD_BEEF);
        wait_done("shl2", 2, 32'h0000_0003, 1'b1, 1'b0);
        issue(2'b10, 2'd1, 1'b0, 32'h0000_0101, 32'h0);
        wait_done("shr2", 2, 32'h0000_0080, 1'b1, 1'b0);
        issue(2'b11, 2'd0, 1'b1, 32'hABCD_12F0, 32'h5A5A_5AFF);
        wait_done("nand1", 1, 32'h0000_000F, 1'b0, 1'b0);
        // Upper operand bytes must not leak into the result or the zero flag.
        issue(2'b00, 2'd0, 1'b0, 32'h1234_56FF, 32'h0000_0001);
        wait_done("add1_hi", 1, 32'h0000_0000, 1'b1, 1'b1);

        issue(2'b10, 2'd3, 1'b1, 32'h8000_0001, 32'h0);
        check("shr4_cmd", 32'(bus.alu_cmd), 32'd2);
        check("shr4_inA", 32'(bus.alu_inA), 32'h80);
        check("shr4_inB", 32'(bus.alu_inB), 32'h00);
        check("shr4_sci", 32'(bus.alu_sc_i), 32'd1);
        wait_done("shr4", 4, 32'hC000_0000, 1'b1, 1'b0);

        issue(2'b00, 2'd3, 1'b0, 32'h0000_0001, 32'h0000_0302);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.len = 2'd0;
        bus.cin = 1'b1;
        bus.a_in = 32'hFFFF_FFFF;
        bus.b_in = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        check("ign_inB", 32'(bus.alu_inB), 32'h03);
        check("ign_ready", 32'(bus.ready), 32'd0);
        wait_done("ign", 4, 32'h0000_0303, 1'b0, 1'b0);
        issue(2'b00, 2'd0, 1'b1, 32'h0000_0010, 32'h0000_0020);
        wait_done("b2b", 1, 32'h0000_0031, 1'b0, 1'b0);

        issue(2'b00, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(bus.ready), 32'd1);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'h0);
        check("arst_cout", 32'(bus.carry_out), 32'd0);
        check("arst_zf", 32'(bus.zero_flag), 32'd1);
        check("arst_inA", 32'(bus.alu_inA), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) tick();
        check("arst_nodone", 32'(done_seen), 32'd0);
        issue(2'b00, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_0001);
        wait_done("post_rst", 1, 32'h0000_0002, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mp_alu_seq.md
MP_ALU_SEQ -- requirements
Module: mp_alu_seq

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-high reset, reset.
REQ-002 Ports SHALL be:
 clk  in  1  rising-edge clock
 reset  in  1  async active-high reset
 start  in  1  request; accepted only when ready=1
 op  in  2  00 ADD, 01 SHL, 10 SHR, 11 NAND
 len  in  2  operand length in bytes minus 1 (0..3 -> 1..4 bytes)
 cin  in  1  initial carry/shift-in bit (ignored for NAND)
 a_in  in  32  operand A, byte 0 = bits 7:0
 b_in  in  32  operand B (ignored for SHL/SHR)
 ready  out  1  high in IDLE only
 done  out  1  one-cycle completion pulse
 result  out  32  result, held until next accepted start
 carry_out  out  1  final ALU carry/shift-out bit
 zero_flag  out  1  all active result bytes zero
 alu_cmd  out  3  command to the datapath ALU
 alu_inA  out  8  ALU operand A byte
 alu_inB  out  8  ALU operand B byte
 alu_sc_i  out  1  ALU carry/shift in
 alu_rslt  in  8  ALU result byte (combinational, same cycle)
 alu_sc_o  in  1  ALU carry/shift out (combinational, same cycle)

Function
REQ-003 The block SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start&&ready, RUN->DONE after the last byte, DONE->IDLE unconditionally next cycle.
REQ-004 On acceptance, a_in, b_in, op, len, cin SHALL be latched; result SHALL be cleared to 0; carry register SHALL load cin (NAND: 0).
REQ-005 start while not IDLE SHALL be ignored with no effect on latched operands or state.
REQ-006 RUN SHALL process exactly len+1 bytes, one per cycle, using a byte index counter.
REQ-007 ADD, SHL, NAND SHALL process byte 0 upward; SHR SHALL process byte len downward to byte 0.
REQ-008 Command mapping SHALL be ADD->3'b000, SHL->3'b001, SHR->3'b010, NAND->3'b011.
REQ-009 In RUN, alu_inA SHALL be latched A byte at the current index; alu_inB SHALL be latched B byte for ADD/NAND, 8'h00 for shifts; alu_sc_i SHALL be the carry register.
REQ-010 Each RUN cycle SHALL write alu_rslt into result byte at the current index and load alu_sc_o into the carry register (NAND: load 0).
REQ-011 Result bytes above len SHALL remain 0.
REQ-012 carry_out SHALL equal the carry register, valid in DONE and held until next acceptance.
REQ-013 zero_flag SHALL be 1 iff result == 0, registered alongside result.
REQ-014 done SHALL be high exactly in the DONE cycle; done for an n-byte operation SHALL assert n+1 cycles after the accepting edge.
REQ-015 Outside RUN, alu_cmd, alu_inA, alu_inB, alu_sc_i SHALL be driven 0.
REQ-016 Back-to-back: start in the cycle after DONE (ready=1) SHALL be accepted.

Reset
REQ-017 reset SHALL immediately force IDLE, ready=1, done=0, result=0, carry_out=0, zero_flag=1, byte index 0, all ALU outputs 0.
REQ-018 reset asserted during RUN SHALL abort the operation with no done pulse; the first post-reset start SHALL run normally.

Verification
REQ-019 ADD len=1, A=0x00FF, B=0x0001, cin=0 -> result=0x00000100, carry_out=0, zero_flag=0, done 3 cycles after acceptance.
REQ-020 ADD len=3, A=0xFFFFFFFF, B=0x00000001, cin=0 -> result=0, carry_out=1, zero_flag=1, done after 5 cycles.
REQ-021 SHL len=1, A=0x8001, cin=1 -> result=0x0003, carry_out=1; SHR len=1, A=0x0101, cin=0 -> result=0x0080, carry_out=1.
REQ-022 NAND len=0, A=0xF0, B=0xFF, garbage upper bytes -> result=0x0000000F, carry_out=0.
REQ-023 start pulsed during RUN with different operands -> ignored, first result unchanged; start in cycle after done -> accepted.
REQ-024 reset asserted mid-RUN of a 4-byte ADD -> outputs at reset values, no done, next 1-byte ADD 0x01+0x01 -> 0x02.
